// File: rtl/result_display_pkg.sv
// Shared types, segment encodings and helpers for the result_display block.
// Segment vectors are {g,f,e,d,c,b,a}, active-low.
package result_display_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StShift,
    StDone
  } conv_state_e;

  typedef logic [1:0] digit_idx_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  // Entry [n] holds the pattern for numeral n.
  localparam logic [9:0][6:0] SEG_DIGIT = {
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] digit);
    logic [6:0] pattern;
    pattern = SEG_BLANK;
    if (digit <= 4'd9) begin
      pattern = SEG_DIGIT[digit];
    end
    return pattern;
  endfunction

endpackage

// File: rtl/result_display_bin2bcd_seq.sv
// Multi-cycle double-dabble engine: sign/magnitude split at load, one shift per cycle,
// start/busy/done handshake. Outputs are stable from the done pulse until the next start.
module bin2bcd_seq
  import result_display_pkg::*;
#(
  parameter int unsigned WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] value,
  output logic             busy,
  output logic             done,
  output logic             neg,
  output logic [1:0]       tens,
  output logic [3:0]       ones
);

  conv_state_e      state_q;
  logic             busy_q;
  logic             done_q;
  logic             neg_q;
  logic [1:0]       tens_q;
  logic [3:0]       ones_q;
  logic [WIDTH:0]   shreg_q;
  logic [2:0]       iter_q;

  logic             neg_in;
  logic [WIDTH:0]   ext_in;
  logic [WIDTH:0]   mag_in;
  logic [3:0]       ones_adj;
  logic [1:0]       tens_step;
  logic [3:0]       ones_step;

  // One extra bit so that the most negative input negates to a positive magnitude.
  always_comb begin
    neg_in = mode & value[WIDTH-1];
    ext_in = {value[WIDTH-1], value};
    mag_in = neg_in ? (~ext_in + 1'b1) : {1'b0, value};
  end

  // Tens never exceeds 1 before the final shift, so it needs no add-3 correction.
  always_comb begin
    ones_adj                = (ones_q >= 4'd5) ? (ones_q + 4'd3) : ones_q;
    {tens_step, ones_step}  = {tens_q[0], ones_adj, shreg_q[WIDTH-1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      neg_q   <= 1'b0;
      tens_q  <= 2'd0;
      ones_q  <= 4'd0;
      shreg_q <= '0;
      iter_q  <= 3'd0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            neg_q   <= neg_in;
            shreg_q <= mag_in;
            tens_q  <= 2'd0;
            ones_q  <= 4'd0;
            iter_q  <= 3'd0;
            busy_q  <= 1'b1;
            state_q <= StLoad;
          end
        end
        StLoad: begin
          tens_q  <= tens_step;
          ones_q  <= ones_step;
          shreg_q <= shreg_q << 1;
          iter_q  <= 3'd1;
          state_q <= StShift;
        end
        StShift: begin
          tens_q  <= tens_step;
          ones_q  <= ones_step;
          shreg_q <= shreg_q << 1;
          iter_q  <= iter_q + 3'd1;
          if (iter_q == 3'(WIDTH - 1)) begin
            done_q  <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign neg  = neg_q;
  assign tens = tens_q;
  assign ones = ones_q;

endmodule

// File: rtl/result_display.sv
// Sign/tens/ones display driver for the adder/subtractor result with 3-digit active-low scan.
// Define RESULT_DISPLAY_LZB_EN to blank a zero tens digit.
module result_display
  import result_display_pkg::*;
#(
  parameter int unsigned WIDTH       = 5,
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] result,
  input  logic             subtract_mode,
  output logic [6:0]       seg,
  output logic [2:0]       an,
  output logic             busy
);

  localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [WIDTH:0]   sync1_q;
  logic [WIDTH:0]   sync2_q;
  logic [1:0]       sync_ok_q;
  logic [WIDTH:0]   last_word_q;
  logic             pending_q;
  logic             start;

  logic             eng_busy;
  logic             eng_done;
  logic             eng_neg;
  logic [1:0]       eng_tens;
  logic [3:0]       eng_ones;

  logic             disp_valid_q;
  logic             disp_neg_q;
  logic [1:0]       disp_tens_q;
  logic [3:0]       disp_ones_q;

  logic [CntW-1:0]  cnt_q;
  digit_idx_t       digit_q;
  logic [6:0]       seg_q;
  logic [6:0]       seg_d;
  logic [2:0]       an_q;
  logic [2:0]       an_d;
  logic [6:0]       tens_seg;

  // sync_ok_q keeps the post-reset flop contents out of the change detector until the
  // synchronizer has filled with the live input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      sync_ok_q <= 2'b00;
    end else begin
      sync1_q   <= {subtract_mode, result};
      sync2_q   <= sync1_q;
      sync_ok_q <= {sync_ok_q[0], 1'b1};
    end
  end

  assign start = ~eng_busy & sync_ok_q[1] & (pending_q | (sync2_q != last_word_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_word_q <= '0;
      pending_q   <= 1'b1;
    end else if (start) begin
      last_word_q <= sync2_q;
      pending_q   <= 1'b0;
    end
  end

  bin2bcd_seq #(
    .WIDTH (WIDTH)
  ) u_bin2bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .mode  (sync2_q[WIDTH]),
    .value (sync2_q[WIDTH-1:0]),
    .busy  (eng_busy),
    .done  (eng_done),
    .neg   (eng_neg),
    .tens  (eng_tens),
    .ones  (eng_ones)
  );

  // Display registers only move on a completed conversion, so a torn value is never shown.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_valid_q <= 1'b0;
      disp_neg_q   <= 1'b0;
      disp_tens_q  <= 2'd0;
      disp_ones_q  <= 4'd0;
    end else if (eng_done) begin
      disp_valid_q <= 1'b1;
      disp_neg_q   <= eng_neg;
      disp_tens_q  <= eng_tens;
      disp_ones_q  <= eng_ones;
    end
  end

  always_comb begin
    tens_seg = bcd_to_seg({2'b00, disp_tens_q});
`ifdef RESULT_DISPLAY_LZB_EN
    if (disp_tens_q == 2'd0) begin
      tens_seg = SEG_BLANK;
    end
`endif
    seg_d = SEG_BLANK;
    an_d  = 3'b111;
    case (digit_q)
      2'd0: begin
        an_d = 3'b110;
        if (disp_valid_q) seg_d = bcd_to_seg(disp_ones_q);
      end
      2'd1: begin
        an_d = 3'b101;
        if (disp_valid_q) seg_d = tens_seg;
      end
      2'd2: begin
        an_d = 3'b011;
        if (disp_neg_q) seg_d = SEG_MINUS;
      end
      default: begin
        an_d  = 3'b111;
        seg_d = SEG_BLANK;
      end
    endcase
  end

  // Outputs are latched at the first cycle of each slot, so content changes only on a slot
  // boundary and seg/an always switch together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      digit_q <= 2'd0;
      seg_q   <= SEG_BLANK;
      an_q    <= 3'b111;
    end else begin
      if (cnt_q == CntW'(REFRESH_DIV - 1)) begin
        cnt_q   <= '0;
        digit_q <= (digit_q == 2'd2) ? 2'd0 : (digit_q + 2'd1);
      end else begin
        cnt_q <= cnt_q + CntW'(1);
      end
      if (cnt_q == '0) begin
        seg_q <= seg_d;
        an_q  <= an_d;
      end
    end
  end

  assign seg  = seg_q;
  assign an   = an_q;
  assign busy = eng_busy;

endmodule

// File: tb/tb_result_display.sv
// Scoreboard bench for result_display: stimulus queues expected sign/tens/ones patterns,
// a monitor pops one per completed conversion and checks each digit as the scan reaches it.
module tb_result_display;

  localparam logic [6:0] S_BL = 7'b1111111;
  localparam logic [6:0] S_MI = 7'b0111111;
  localparam logic [6:0] S_0  = 7'b1000000;
  localparam logic [6:0] S_1  = 7'b1111001;
  localparam logic [6:0] S_2  = 7'b0100100;
  localparam logic [6:0] S_3  = 7'b0110000;
  localparam logic [6:0] S_5  = 7'b0010010;
  localparam logic [6:0] S_6  = 7'b0000010;
`ifdef RESULT_DISPLAY_LZB_EN
  localparam logic [6:0] S_TZ = S_BL;
`else
  localparam logic [6:0] S_TZ = S_0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] result = 5'd0;
  logic       subtract_mode = 1'b0;
  logic [6:0] seg;
  logic [2:0] an;
  logic       busy;

  int total = 0;
  int bad = 0;
  int pushed = 0;
  int closed = 0;
  logic [20:0] exp_q[$];

  result_display #(
    .WIDTH       (5),
    .REFRESH_DIV (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .result        (result),
    .subtract_mode (subtract_mode),
    .seg           (seg),
    .an            (an),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0b want %0b", name, act, req);
    end
  endtask

  task automatic push(input logic [6:0] s, input logic [6:0] t, input logic [6:0] o);
    exp_q.push_back({s, t, o});
    pushed++;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (closed != pushed && n < 400) begin
      @(negedge clk);
      n++;
    end
    check(name, closed, pushed);
  endtask

  task automatic wait_busy(input logic lvl, input string name);
    int n;
    n = 0;
    while (busy !== lvl && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(name, busy, lvl);
  endtask

  task automatic vec(input logic [4:0] r, input logic m, input logic [6:0] s,
                     input logic [6:0] t, input logic [6:0] o, input string name);
    @(negedge clk);
    result        = r;
    subtract_mode = m;
    push(s, t, o);
    drain(name);
  endtask

  // A slot latched on the same edge as the busy fall still shows the old value, so the
  // monitor only attributes slots seen on later cycles to the new result.
  initial begin : monitor
    logic [20:0] cur;
    logic        active;
    logic [2:0]  got;
    logic        busy_prev;
    logic [2:0]  an_prev;
    cur = '0;
    active = 1'b0;
    got = 3'b000;
    busy_prev = 1'b0;
    an_prev = 3'b111;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        active    = 1'b0;
        busy_prev = 1'b0;
        an_prev   = 3'b111;
      end else begin
        if (busy_prev && !busy) begin
          if (active) closed++;
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_result: got a completed conversion, want none");
            active = 1'b0;
          end else begin
            cur    = exp_q.pop_front();
            active = 1'b1;
            got    = 3'b000;
          end
        end else if (active && an != an_prev) begin
          check("an_onehot", $countones(~an), 1);
          case (an)
            3'b110: begin check("ones", seg, cur[6:0]);   got[0] = 1'b1; end
            3'b101: begin check("tens", seg, cur[13:7]);  got[1] = 1'b1; end
            3'b011: begin check("sign", seg, cur[20:14]); got[2] = 1'b1; end
            default: ;
          endcase
          if (got == 3'b111) begin
            active = 1'b0;
            closed++;
          end
        end
        busy_prev = busy;
        an_prev   = an;
      end
    end
  end

  initial begin : stim
    int n;
    // Reset state, then the pending conversion of the held input (0).
    repeat (2) @(negedge clk);
    check("rst_seg", seg, S_BL);
    check("rst_an", an, 3'b111);
    check("rst_busy", busy, 1'b0);
    push(S_BL, S_TZ, S_0);
    rst_n = 1'b1;
    @(negedge clk);
    check("first_an", an, 3'b110);
    drain("reset_conv");

    // 0 + 6 with busy timing against the edge count.
    @(negedge clk);
    result = 5'b00110;
    subtract_mode = 1'b0;
    push(S_BL, S_TZ, S_6);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("busy_edge2", busy, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("busy_edge3", busy, 1'b1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("busy_edge8", busy, 1'b1);
    @(posedge clk);
    @(negedge clk);
    check("busy_edge9", busy, 1'b0);
    drain("v_6");

    vec(5'b00101, 1'b1, S_BL, S_TZ, S_5, "v_7m2");
    vec(5'b10100, 1'b0, S_BL, S_2,  S_0, "v_20");
    vec(5'b11011, 1'b1, S_MI, S_TZ, S_5, "v_m5");
    vec(5'b11110, 1'b0, S_BL, S_3,  S_0, "v_30");
    vec(5'b10000, 1'b1, S_MI, S_1,  S_6, "v_m16");

    // Input change during SHIFT: 6 must land first, then 20.
    @(negedge clk);
    result = 5'b00110;
    subtract_mode = 1'b0;
    push(S_BL, S_TZ, S_6);
    wait_busy(1'b1, "chg_start");
    repeat (2) @(negedge clk);
    result = 5'b10100;
    push(S_BL, S_2, S_0);
    wait_busy(1'b0, "chg_first_done");
    n = 0;
    while (!busy && n < 4) begin
      @(negedge clk);
      n++;
    end
    check("chg_rebusy", (busy && n <= 2), 1);
    drain("chg");

    // Reset in the middle of SHIFT with -5 held on the inputs.
    @(negedge clk);
    result = 5'b11011;
    subtract_mode = 1'b1;
    wait_busy(1'b1, "rst_conv_start");
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_seg", seg, S_BL);
    check("midrst_an", an, 3'b111);
    check("midrst_busy", busy, 1'b0);
    repeat (2) @(negedge clk);
    push(S_MI, S_TZ, S_5);
    rst_n = 1'b1;
    drain("rst_reconv");

    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
